// File: rtl/btn_pkg.sv
// Shared types and constants for the button event decoder.
// Holds the per-bit FSM encoding, default timings and a counter-width helper.
package btn_pkg;

  localparam int unsigned LONG_CYC_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYC_DEF = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } btn_state_e;

  // parked = counter frozen, no further pulses until the button is released
  typedef struct packed {
    btn_state_e st;
    logic       parked;
  } btn_fsm_t;

  localparam btn_fsm_t FSM_IDLE = '{st: ST_IDLE, parked: 1'b0};

  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 32'd1);
  endfunction

endpackage

// File: rtl/btn_event_if.sv
// Button level inputs and event pulse outputs for an N-wide button bank.
interface btn_event_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] pbreg;
  logic [N-1:0] repeat_en;
  logic [N-1:0] press;
  logic [N-1:0] release_ev;
  logic [N-1:0] long;
  logic [N-1:0] repeat_ev;
  logic [N-1:0] held;

  modport master (
    output pbreg, repeat_en,
    input  press, release_ev, long, repeat_ev, held
  );

  modport slave (
    input  pbreg, repeat_en,
    output press, release_ev, long, repeat_ev, held
  );
endinterface

// File: rtl/btn_event_1.sv
// Single-button event FSM: press/release edges, long-press and auto-repeat pulses.
// All pulses are registered and last exactly one cycle.
module btn_event_1
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
  parameter int unsigned CNT_W      = clog2_max(LONG_CYC, REPEAT_CYC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  input  logic rep_en,
  output logic press,
  output logic release_ev,
  output logic long,
  output logic repeat_ev,
  output logic held
);

  btn_fsm_t         fsm, fsm_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             prev;
  logic             rise, fall;
  logic             press_nxt, release_nxt, long_nxt, repeat_nxt;

  assign rise = pb & ~prev;
  assign fall = ~pb & prev;
  assign held = prev;

  // State, counter, edge history and output pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= FSM_IDLE;
      cnt        <= '0;
      prev       <= 1'b0;
      press      <= 1'b0;
      release_ev <= 1'b0;
      long       <= 1'b0;
      repeat_ev  <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      cnt        <= cnt_nxt;
      prev       <= pb;
      press      <= press_nxt;
      release_ev <= release_nxt;
      long       <= long_nxt;
      repeat_ev  <= repeat_nxt;
    end
  end

  // Press loads cnt with 1, so the HOLD terminal is LONG_CYC to land the
  // long pulse exactly LONG_CYC cycles after the press pulse.
  always_comb begin
    fsm_nxt     = fsm;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (fsm.st)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          press_nxt = 1'b1;
          cnt_nxt   = CNT_W'(1);
          fsm_nxt   = '{st: ST_HOLD, parked: 1'b0};
        end
      end
      ST_HOLD: begin
        if (fall) begin
          release_nxt = 1'b1;
          cnt_nxt     = '0;
          fsm_nxt     = FSM_IDLE;
        end else if (!fsm.parked) begin
          if (cnt == CNT_W'(LONG_CYC)) begin
            long_nxt = 1'b1;
            cnt_nxt  = '0;
            if (rep_en) fsm_nxt = '{st: ST_REPEAT, parked: 1'b0};
            else        fsm_nxt.parked = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          release_nxt = 1'b1;
          cnt_nxt     = '0;
          fsm_nxt     = FSM_IDLE;
        end else if (!fsm.parked) begin
          if (!rep_en) begin
            fsm_nxt.parked = 1'b1;
          end else if (cnt == CNT_W'(REPEAT_CYC - 1)) begin
            repeat_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt = '0;
        fsm_nxt = FSM_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/btn_event.sv
// N-wide button event decoder: one independent btn_event_1 per debounced button.
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input logic        clk,
  input logic        rst_n,
  btn_event_if.slave bus
);

  localparam int unsigned CNT_W = clog2_max(LONG_CYC, REPEAT_CYC);

  for (genvar i = 0; i < N; i++) begin : g_bit
    btn_event_1 #(
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .pb         (bus.pbreg[i]),
      .rep_en     (bus.repeat_en[i]),
      .press      (bus.press[i]),
      .release_ev (bus.release_ev[i]),
      .long       (bus.long[i]),
      .repeat_ev  (bus.repeat_ev[i]),
      .held       (bus.held[i])
    );
  end

endmodule

// File: tb/tb_btn_event.sv
// Table-driven bench for btn_event (N=4, LONG_CYC=10, REPEAT_CYC=4).
// Each row's expected pulses are those caused by the edge that samples the row's inputs.
module tb_btn_event;

  typedef struct {
    logic       rst_n;
    logic [3:0] pb;
    logic [3:0] ren;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rpt;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rpt;
    logic [3:0] held;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  btn_event_if #(.N(4)) bus ();

  btn_event #(
    .N          (4),
    .LONG_CYC   (10),
    .REPEAT_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] pb, input logic [3:0] ren,
                     input logic [3:0] p, input logic [3:0] rl,
                     input logic [3:0] lg, input logic [3:0] rp);
    vec_t v;
    v.rst_n = r;  v.pb  = pb; v.ren = ren;
    v.press = p;  v.rel = rl; v.lng = lg; v.rpt = rp;
    vecs.push_back(v);
  endtask

  task automatic quiet(input int n, input logic [3:0] pb, input logic [3:0] ren);
    for (int k = 0; k < n; k++) add(1'b1, pb, ren, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic chk(input string nm, input int row, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s row %0d: got %b want %b", nm, row, got, want);
    end
  endtask

  initial begin
    exp_t e;
    vec_t v;
    rst_n         = 1'b0;
    bus.pbreg     = 4'h0;
    bus.repeat_en = 4'h0;

    // 1: reset, idle, short press on bit 0
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    quiet(20, 4'h0, 4'h0);
    add(1'b1, 4'b0001, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0);
    quiet(4, 4'b0001, 4'h0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0);
    quiet(3, 4'h0, 4'h0);

    // 2: bit 1 long hold with repeat: long at +10, repeats at +14,+18,...,+30
    for (int k = 0; k <= 30; k++)
      add(1'b1, 4'b0010, 4'b0010,
          (k == 0)  ? 4'b0010 : 4'h0, 4'h0,
          (k == 10) ? 4'b0010 : 4'h0,
          (k >= 14 && (k - 10) % 4 == 0) ? 4'b0010 : 4'h0);
    add(1'b1, 4'h0, 4'b0010, 4'h0, 4'b0010, 4'h0, 4'h0);
    quiet(2, 4'h0, 4'h0);

    // 3: bit 2 long hold without repeat: parks after long
    for (int k = 0; k < 30; k++)
      add(1'b1, 4'b0100, 4'h0,
          (k == 0)  ? 4'b0100 : 4'h0, 4'h0,
          (k == 10) ? 4'b0100 : 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0);
    quiet(2, 4'h0, 4'h0);

    // 4: fall on the long terminal count, then fall/rise on consecutive edges
    add(1'b1, 4'b1000, 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0);
    quiet(9, 4'b1000, 4'b1000);
    add(1'b1, 4'h0, 4'b1000, 4'h0, 4'b1000, 4'h0, 4'h0);
    quiet(1, 4'h0, 4'h0);
    add(1'b1, 4'b1000, 4'h0, 4'b1000, 4'h0, 4'h0, 4'h0);
    quiet(2, 4'b1000, 4'h0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0);
    add(1'b1, 4'b1000, 4'h0, 4'b1000, 4'h0, 4'h0, 4'h0);
    quiet(1, 4'b1000, 4'h0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0);
    quiet(2, 4'h0, 4'h0);

    // 5: all four together, reset mid-hold, press again from reset
    add(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    quiet(3, 4'hF, 4'h0);
    add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    quiet(2, 4'hF, 4'h0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    quiet(2, 4'h0, 4'h0);

    // 6: repeat_en drops exactly on a repeat terminal, restored while held
    for (int k = 0; k <= 30; k++)
      add(1'b1, 4'b0010, (k >= 18 && k <= 20) ? 4'h0 : 4'b0010,
          (k == 0)  ? 4'b0010 : 4'h0, 4'h0,
          (k == 10) ? 4'b0010 : 4'h0,
          (k == 14) ? 4'b0010 : 4'h0);
    add(1'b1, 4'h0, 4'b0010, 4'h0, 4'b0010, 4'h0, 4'h0);
    quiet(2, 4'h0, 4'h0);

    // Drive each row, push its expectation, pop and compare after the edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v             = vecs[i];
      rst_n         = v.rst_n;
      bus.pbreg     = v.pb;
      bus.repeat_en = v.ren;
      e.row   = i;
      e.press = v.press;
      e.rel   = v.rel;
      e.lng   = v.lng;
      e.rpt   = v.rpt;
      e.held  = v.rst_n ? v.pb : 4'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("press",   e.row, bus.press,      e.press);
      chk("release", e.row, bus.release_ev, e.rel);
      chk("long",    e.row, bus.long,       e.lng);
      chk("repeat",  e.row, bus.repeat_ev,  e.rpt);
      chk("held",    e.row, bus.held,       e.held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
